// File: rtl/simon_playback_sequencer.sv
// simon_playback_sequencer: replays stored LED patterns 0..n-1 in the order
// fetch, hold, then gap, and pulses done once the whole sequence has played.
`default_nettype none

module simon_playback_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              led_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHOW  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [7:0]      HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]      GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] len, len_nxt;
  logic [ADDR_W:0] i, i_nxt;
  logic [7:0]      dwell, dwell_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      i     <= '0;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      i     <= i_nxt;
      dwell <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    i_nxt     = i;
    dwell_nxt = dwell;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          len_nxt   = (n > MAX_LEN) ? MAX_LEN : n;
          i_nxt     = '0;
          dwell_nxt = '0;
          state_nxt = (n == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        dwell_nxt = HOLD_LOAD;
        state_nxt = SHOW;
      end
      SHOW: begin
        if (dwell == 8'd0) begin
          dwell_nxt = GAP_LOAD;
          state_nxt = GAP;
        end else begin
          dwell_nxt = dwell - 8'd1;
        end
      end
      GAP: begin
        if (dwell == 8'd0) begin
          dwell_nxt = '0;
          // Index stops at len-1 so it can never wrap inside a sequence.
          if (i == len - ONE) begin
            state_nxt = DONE;
          end else begin
            i_nxt     = i + ONE;
            state_nxt = FETCH;
          end
        end else begin
          dwell_nxt = dwell - 8'd1;
        end
      end
      DONE: begin
        dwell_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      dwell_nxt = '0;
    end
  end

  // Every output is a pure decode of registered state.
  assign mem_addr  = i[ADDR_W-1:0];
  assign mem_rd_en = (state == FETCH);
  assign led_en    = (state == SHOW);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_simon_playback_sequencer.sv
// tb_simon_playback_sequencer: directed scenario tests for the playback sequencer.
`default_nettype none

module tb_simon_playback_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [6:0] n;
  logic [5:0] mem_addr;
  logic       mem_rd_en;
  logic       led_en;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  int done_k;
  int shape_err;
  int strobe_addr[$];
  int strobe_k[$];

  simon_playback_sequencer #(.ADDR_W(6), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n(n),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .led_en(led_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the sample point of cycle 1 (just after the start edge).
  task automatic pulse_start(input logic [6:0] nv);
    start = 1'b1;
    n     = nv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs from cycle 1 until done (or max_k), recording strobes and comparing each
  // cycle against the expected fetch/show/gap shape with a 7-cycle period.
  task automatic observe(input int exp_len, input int max_k, input int restart_k);
    int p;
    done_k    = 0;
    shape_err = 0;
    strobe_addr.delete();
    strobe_k.delete();
    for (int k = 1; k <= max_k; k++) begin
      if (mem_rd_en === 1'b1) begin
        strobe_addr.push_back(int'(mem_addr));
        strobe_k.push_back(k);
      end
      if (k <= 7 * exp_len) begin
        p = (k - 1) % 7;
        if (mem_rd_en !== (p == 0)) shape_err++;
        if (led_en !== (p >= 1 && p <= 4)) shape_err++;
        if (mem_addr !== 6'((k - 1) / 7)) shape_err++;
        if (busy !== 1'b1 || done !== 1'b0) shape_err++;
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (k == restart_k) begin
        start = 1'b1;
        n     = 7'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({mem_addr, mem_rd_en, led_en, busy, done} !== 10'd0) begin
      $display("FAIL reset_outputs: got %b expected 0", {mem_addr, mem_rd_en, led_en, busy, done});
      fails++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
      fails++;
    end
  endtask

  task automatic test_n3();
    pulse_start(7'd3);
    observe(3, 40, 0);
    tests++;
    if (done_k !== 22) begin
      $display("FAIL n3_done_cycle: got %0d expected 22", done_k); fails++;
    end
    tests++;
    if (shape_err !== 0) begin
      $display("FAIL n3_shape: got %0d errors expected 0", shape_err); fails++;
    end
    tests++;
    if (strobe_addr.size() !== 3 || strobe_addr[0] !== 0 || strobe_addr[1] !== 1 || strobe_addr[2] !== 2) begin
      $display("FAIL n3_addrs: got %0d strobes expected 3 at addr 0,1,2", strobe_addr.size()); fails++;
    end
    tests++;
    if (strobe_k.size() !== 3 || strobe_k[0] !== 1 || strobe_k[1] !== 8 || strobe_k[2] !== 15) begin
      $display("FAIL n3_strobe_spacing: got %0d strobes expected cycles 1,8,15", strobe_k.size()); fails++;
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL n3_back_idle: got busy=%b done=%b expected 0 0", busy, done); fails++;
    end
  endtask

  task automatic test_n0();
    pulse_start(7'd0);
    observe(0, 10, 0);
    tests++;
    if (done_k !== 1 || busy !== 1'b1) begin
      $display("FAIL n0_done: got cycle %0d busy=%b expected 1 1", done_k, busy); fails++;
    end
    tests++;
    if (strobe_addr.size() !== 0) begin
      $display("FAIL n0_no_read: got %0d strobes expected 0", strobe_addr.size()); fails++;
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL n0_idle: got busy=%b expected 0", busy); fails++;
    end
  endtask

  task automatic test_abort();
    int seen_done = 0;
    pulse_start(7'd2);
    repeat (2) begin @(posedge clk); #1; end
    tests++;
    if (led_en !== 1'b1) begin
      $display("FAIL abort_in_show: got led_en=%b expected 1", led_en); fails++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if ({busy, led_en, mem_rd_en, done} !== 4'b0000) begin
      $display("FAIL abort_outputs: got %b expected 0000", {busy, led_en, mem_rd_en, done}); fails++;
    end
    repeat (20) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen_done !== 0) begin
      $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done); fails++;
    end
  endtask

  task automatic test_start_ignored();
    pulse_start(7'd3);
    observe(3, 40, 5);
    tests++;
    if (done_k !== 22 || shape_err !== 0) begin
      $display("FAIL restart_ignored: got done %0d errs %0d expected 22 0", done_k, shape_err); fails++;
    end
    tests++;
    if (strobe_addr.size() !== 3 || strobe_addr[2] !== 2) begin
      $display("FAIL restart_addrs: got %0d strobes expected 3", strobe_addr.size()); fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    pulse_start(7'd3);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({mem_addr, mem_rd_en, led_en, busy, done} !== 10'd0) begin
      $display("FAIL async_rst_outputs: got %b expected 0", {mem_addr, mem_rd_en, led_en, busy, done}); fails++;
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    pulse_start(7'd1);
    observe(1, 30, 0);
    tests++;
    if (done_k !== 8 || shape_err !== 0 || strobe_addr.size() !== 1 || strobe_addr[0] !== 0) begin
      $display("FAIL async_rst_rerun: got done %0d errs %0d strobes %0d expected 8 0 1", done_k, shape_err, strobe_addr.size()); fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort_start_idle();
    int reads = 0;
    start = 1'b1;
    abort = 1'b1;
    n     = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL abort_wins_idle: got busy=%b expected 0", busy); fails++;
    end
    repeat (10) begin
      if (mem_rd_en === 1'b1 || busy === 1'b1) reads++;
      @(posedge clk); #1;
    end
    tests++;
    if (reads !== 0) begin
      $display("FAIL abort_wins_quiet: got %0d active cycles expected 0", reads); fails++;
    end
  endtask

  task automatic test_long(input logic [6:0] nv, input string name);
    int bad = 0;
    pulse_start(nv);
    observe(64, 500, 0);
    tests++;
    if (done_k !== 449 || shape_err !== 0) begin
      $display("FAIL %s_done: got done %0d errs %0d expected 449 0", name, done_k, shape_err); fails++;
    end
    foreach (strobe_addr[j]) if (strobe_addr[j] !== j) bad++;
    tests++;
    if (strobe_addr.size() !== 64 || bad !== 0) begin
      $display("FAIL %s_order: got %0d strobes %0d out of order expected 64 0", name, strobe_addr.size(), bad); fails++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    n     = 7'd0;
    #1;
    test_reset();
    test_n3();
    test_n0();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_abort_start_idle();
    test_long(7'd64, "n64");
    test_long(7'd100, "clamp");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
